// File: rtl/dyser_input_port.sv
`default_nettype none
// ============================================================================
// Module      : dyser_input_port
// Description : Credit-based token transmitter at the DySER fabric boundary.
//               Buffers host tokens ({data, tok_valid}) in a small FIFO and
//               launches the head token onto the fabric path only while a
//               downstream credit is held. In configuration mode the host
//               word is passed combinationally onto the path instead.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               in_data/in_tok_valid/in_push/in_ready - host token interface
//               conf_en             - configuration shift mode
//               c_in                - credit-return pulse (1 cycle = 1 credit)
//               d_out               - fabric path {data, valid, ready}
//               fifo_count          - occupied FIFO entries
//               credit_count        - credits currently held
//               credit_err          - sticky credit-overflow flag
// Revision    : 1.0 - initial release
// ============================================================================
module dyser_input_port #(
    parameter int  ID         = 0,
    parameter int  FIFO_DEPTH = 4,
    parameter int  CREDITS    = 2,
    localparam int META_BITS  = 2,
    localparam int PATH_WIDTH = 32 + META_BITS - 1,
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1,
    localparam int CRD_W      = $clog2(CREDITS) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           in_data,
    input  logic                  in_tok_valid,
    input  logic                  in_push,
    output logic                  in_ready,
    input  logic                  conf_en,
    input  logic                  c_in,
    output logic [PATH_WIDTH:0]   d_out,
    output logic [CNT_W-1:0]      fifo_count,
    output logic [CRD_W-1:0]      credit_count,
    output logic                  credit_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] C_FULL    = CNT_W'(FIFO_DEPTH);
    localparam logic [CRD_W-1:0] C_CRD_MAX = CRD_W'(CREDITS);

    // Port identifier kept as a constant net so trace/debug probes can see it.
    logic [31:0] w_unused_id;
    assign w_unused_id = 32'(ID);

    // Token storage: {data, tok_valid}
    logic [32:0]          r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic [CRD_W-1:0]     r_credits;
    logic                 r_err;
    logic [PATH_WIDTH:0]  r_out;

    logic                 w_full;
    logic                 w_wr;
    logic                 w_send;
    logic                 w_ret;
    logic [32:0]          w_head;

    assign w_full   = (r_count == C_FULL);
    // Full is judged on the current count, so a same-cycle pop never makes
    // room for a push.
    assign in_ready = ~rst & (conf_en | ~w_full);
    assign w_wr     = in_push & ~conf_en & ~w_full;
    assign w_send   = ~conf_en & (r_count != '0) & (r_credits != '0);
    assign w_ret    = c_in & ~conf_en;
    assign w_head   = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_wr && !rst) begin
            r_mem[r_wr_ptr] <= {in_data, in_tok_valid};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_credits <= C_CRD_MAX;
            r_err     <= 1'b0;
            r_out     <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_send) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            case ({w_wr, w_send})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            // A send paired with a return nets to zero; a lone return at the
            // ceiling is a protocol violation and saturates.
            case ({w_send, w_ret})
                2'b10: r_credits <= r_credits - 1'b1;
                2'b01: begin
                    if (r_credits == C_CRD_MAX) begin
                        r_err <= 1'b1;
                    end else begin
                        r_credits <= r_credits + 1'b1;
                    end
                end
                default: r_credits <= r_credits;
            endcase

            // Output register: ready bit is a one-cycle pulse, data holds.
            if (w_send) begin
                r_out <= {w_head[32:1], w_head[0], 1'b1};
            end else if (!conf_en) begin
                r_out <= {r_out[PATH_WIDTH:META_BITS], 2'b00};
            end
        end
    end

    assign d_out        = (conf_en && !rst) ? {in_data, 2'b00} : r_out;
    assign fifo_count   = r_count;
    assign credit_count = r_credits;
    assign credit_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dyser_input_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_dyser_input_port
// Description : Self-checking bench for dyser_input_port. Stimulus pushes the
//               expected fabric token into a scoreboard queue; a monitor pops
//               and compares on every ready pulse of d_out.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dyser_input_port;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_tok_valid;
    logic        in_push;
    logic        in_ready;
    logic        conf_en;
    logic        c_in;
    logic [33:0] d_out;
    logic [2:0]  fifo_count;
    logic [1:0]  credit_count;
    logic        credit_err;

    int checks = 0;
    int errors = 0;
    logic [33:0] exp_q[$];

    always #5 clk = ~clk;

    dyser_input_port #(.ID(0), .FIFO_DEPTH(4), .CREDITS(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_tok_valid (in_tok_valid),
        .in_push      (in_push),
        .in_ready     (in_ready),
        .conf_en      (conf_en),
        .c_in         (c_in),
        .d_out        (d_out),
        .fifo_count   (fifo_count),
        .credit_count (credit_count),
        .credit_err   (credit_err)
    );

    task automatic check(input string name, input logic [33:0] got, input logic [33:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every ready pulse must match the oldest expected token.
    always @(negedge clk) begin
        if (!rst && !conf_en && d_out[0] === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_token: got %h expected none", d_out);
            end else begin
                logic [33:0] e;
                e = exp_q.pop_front();
                if (d_out !== e) begin
                    errors++;
                    $display("FAIL token: got %h expected %h", d_out, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_data = '0; in_tok_valid = 1'b0; in_push = 1'b0;
        conf_en = 1'b0; c_in = 1'b0;
        tick();
        check("ready_in_reset", {33'd0, in_ready}, 34'd0);
        tick();
        rst = 1'b0;
        #1;
        // Reset values
        check("rst_credits", {32'd0, credit_count}, 34'd2);
        check("rst_fifo", {31'd0, fifo_count}, 34'd0);
        check("rst_dout", d_out, 34'd0);
        check("rst_err", {33'd0, credit_err}, 34'd0);
        check("ready_after_rst", {33'd0, in_ready}, 34'd1);

        // First token latency
        in_push = 1'b1; in_data = 32'hA5A5A5A5; in_tok_valid = 1'b1;
        exp_q.push_back({32'hA5A5A5A5, 1'b1, 1'b1});
        tick();
        in_push = 1'b0;
        check("fifo_after_push", {31'd0, fifo_count}, 34'd1);
        tick();
        check("first_dout", d_out, {32'hA5A5A5A5, 2'b11});
        check("credit_after_send", {32'd0, credit_count}, 34'd1);
        tick();
        check("dout_pulse_end", d_out, {32'hA5A5A5A5, 2'b00});
        c_in = 1'b1; tick(); c_in = 1'b0;
        check("credit_returned", {32'd0, credit_count}, 34'd2);

        // Credit exhaustion: tokens 1..4, token 2 predicated off
        for (int i = 1; i <= 4; i++) begin
            in_push = 1'b1; in_data = 32'(i); in_tok_valid = (i != 2);
            exp_q.push_back({32'(i), (i != 2), 1'b1});
            tick();
        end
        in_push = 1'b0;
        check("exh_fifo", {31'd0, fifo_count}, 34'd2);
        check("exh_credit", {32'd0, credit_count}, 34'd0);
        c_in = 1'b1; tick(); c_in = 1'b0;
        tick();
        check("tok3_fifo", {31'd0, fifo_count}, 34'd1);
        check("tok3_credit", {32'd0, credit_count}, 34'd0);
        tick(); tick();
        check("tok4_held", {31'd0, fifo_count}, 34'd1);

        // Full FIFO
        for (int i = 5; i <= 7; i++) begin
            in_push = 1'b1; in_data = 32'(i); in_tok_valid = 1'b1;
            exp_q.push_back({32'(i), 1'b1, 1'b1});
            tick();
        end
        in_push = 1'b0;
        check("full_fifo", {31'd0, fifo_count}, 34'd4);
        check("full_ready", {33'd0, in_ready}, 34'd0);
        in_push = 1'b1; in_data = 32'd8;
        tick();
        check("drop_push", {31'd0, fifo_count}, 34'd4);
        in_data = 32'd9; c_in = 1'b1;
        tick();
        c_in = 1'b0;
        tick();
        in_push = 1'b0;
        check("pop_no_bypass", {31'd0, fifo_count}, 34'd3);
        check("pop_credit", {32'd0, credit_count}, 34'd0);

        // Simultaneous send and return
        c_in = 1'b1; tick();
        check("ret_credit", {32'd0, credit_count}, 34'd1);
        tick();
        c_in = 1'b0;
        check("send_ret_same", {32'd0, credit_count}, 34'd1);
        check("send_ret_fifo", {31'd0, fifo_count}, 34'd2);
        tick();
        check("send6_credit", {32'd0, credit_count}, 34'd0);
        c_in = 1'b1; tick(); c_in = 1'b0; tick();
        check("drained", {31'd0, fifo_count}, 34'd0);
        c_in = 1'b1; tick(); tick();
        check("refill_credit", {32'd0, credit_count}, 34'd2);
        check("no_err_yet", {33'd0, credit_err}, 34'd0);
        tick();
        c_in = 1'b0;
        check("sat_credit", {32'd0, credit_count}, 34'd2);
        check("err_set", {33'd0, credit_err}, 34'd1);
        tick(); tick();
        check("err_sticky", {33'd0, credit_err}, 34'd1);

        // Clear error, then configuration mode with a queued token
        rst = 1'b1; tick(); rst = 1'b0; #1;
        check("err_cleared", {33'd0, credit_err}, 34'd0);
        in_push = 1'b1; in_data = 32'h55; in_tok_valid = 1'b1;
        exp_q.push_back({32'h55, 1'b1, 1'b1});
        tick();
        in_push = 1'b0; conf_en = 1'b1; in_data = 32'h11; c_in = 1'b1;
        #1;
        check("conf_w1", d_out, {32'h11, 2'b00});
        tick();
        c_in = 1'b0; in_data = 32'h22; #1;
        check("conf_w2", d_out, {32'h22, 2'b00});
        tick();
        in_data = 32'h33; #1;
        check("conf_w3", d_out, {32'h33, 2'b00});
        check("conf_fifo", {31'd0, fifo_count}, 34'd1);
        check("conf_credit", {32'd0, credit_count}, 34'd2);
        check("conf_cin_ignored", {33'd0, credit_err}, 34'd0);
        check("conf_ready", {33'd0, in_ready}, 34'd1);
        tick();
        conf_en = 1'b0; in_data = 32'h0; #1;
        check("conf_exit_dout", d_out, 34'd0);
        tick();
        check("resume_credit", {32'd0, credit_count}, 34'd1);
        check("resume_fifo", {31'd0, fifo_count}, 34'd0);

        // Invalid token
        in_push = 1'b1; in_data = 32'h7; in_tok_valid = 1'b0;
        exp_q.push_back({32'h7, 1'b0, 1'b1});
        tick();
        in_push = 1'b0;
        tick();
        check("invalid_meta", {32'd0, d_out[1:0]}, 34'b01);

        // Reset mid-operation: queued tokens must be discarded
        for (int i = 0; i < 3; i++) begin
            in_push = 1'b1; in_data = 32'hB1 + 32'(i); in_tok_valid = 1'b1;
            tick();
        end
        in_push = 1'b0;
        check("mid_fifo", {31'd0, fifo_count}, 34'd3);
        rst = 1'b1; #1;
        check("mid_rst_ready", {33'd0, in_ready}, 34'd0);
        tick();
        check("mid_rst_fifo", {31'd0, fifo_count}, 34'd0);
        check("mid_rst_credit", {32'd0, credit_count}, 34'd2);
        check("mid_rst_dout", d_out, 34'd0);
        rst = 1'b0;
        repeat (6) tick();
        check("scoreboard_empty", 34'(exp_q.size()), 34'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dyser_input_port.md
# dyser_input_port

Credit-based transmitter at the DySER fabric boundary: accepts tokens (32-bit data plus a valid flag) from the host-side input queue and drives them onto a fabric data path in the `{data, valid, ready}` path format consumed by switches and functional units. It buffers tokens in a small FIFO and launches one only while it holds a downstream credit. Credits are returned as single-cycle pulses on `c_in`. While `conf_en` is high it becomes a transparent configuration source that shifts host words straight onto the path.

## Interface
- `ID`, default 0, port identifier for debug/trace.
- `FIFO_DEPTH`, default 4, token buffer entries (power of 2, ≥2).
- `CREDITS`, default 2, initial/max credits; equals the downstream stage buffer depth.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  32  host token data.
- `in_tok_valid`  in  1  token valid flag. 0 = predicated-off token that is still delivered.
- `in_push`  in  1  host offers a token this cycle.
- `in_ready`  out  1  port accepts the offered token this cycle.
- `conf_en`  in  1  configuration shift mode.
- `c_in`  in  1  credit-return pulse from downstream (1 cycle = 1 credit).
- `d_out`  out  `PATH_WIDTH`+1  fabric path. `[PATH_WIDTH:META_BITS]` = data, `[1]` = valid, `[0]` = ready.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  occupied entries.
- `credit_count`  out  $clog2(CREDITS)+1  credits held.
- `credit_err`  out  1  sticky; set when a credit returns while `credit_count == CREDITS`.

## Operation
- **Push:** a token is written when `in_push & in_ready` at the edge. `in_ready = ~rst & (conf_en | fifo_count != FIFO_DEPTH)`. There is no full-bypass: a pop does not free space for a push in the same cycle.
- **Send condition:** `~conf_en & fifo_count != 0 & credit_count != 0`. At the edge where it holds:
  - the head token is popped;
  - the registered output loads `{data, tok_valid, 1'b1}`;
  - the credit is decremented.
- **No send:** the registered output loads `{held data, 1'b0, 1'b0}`. Data holds the last sent value; both meta bits clear. The ready bit is therefore a one-cycle pulse per token.
- **Credits:**
  - next = current − send + (`c_in` & ~`conf_en`).
  - A send and a credit return in the same cycle leave the count unchanged.
  - A return at `CREDITS` with no simultaneous send saturates at `CREDITS` and sets `credit_err`.
  - A send never occurs at 0 credits.
- **Ordering:** tokens are strict FIFO. Invalid tokens consume a FIFO entry and a credit exactly like valid ones.
- **conf_en = 1:**
  - `d_out = {in_data, 2'b00}` combinationally.
  - `in_ready = 1`.
  - FIFO, credits and the output register are frozen.
  - `c_in` is ignored.
  - The host must present one config word per cycle.
- **conf_en 1→0:** `d_out` returns to the registered output immediately. Normal sending resumes on the next edge.
- **Reset:**
  - Any cycle with `rst = 1` empties the FIFO, sets `credit_count = CREDITS` and clears `credit_err`. Tokens in flight are discarded.
  - Output reset values: `d_out = 0`, `fifo_count = 0`, `credit_count = CREDITS`, `credit_err = 0`, `in_ready = 0` while `rst` is high.
  - Reset overrides `conf_en`.

## Timing
- **Latency:** a token pushed at edge k, into an empty FIFO with credit available, is popped at edge k+1. `d_out[0] = 1` during cycle k+1→k+2. Minimum latency is 2 edges.
- **Throughput:** one token per cycle when there is no back-pressure and `CREDITS` covers the downstream round trip.
- **Counters:** `fifo_count` updates at the edge of a push or pop; a simultaneous push and pop leaves it unchanged.
- **Credit visibility:** `credit_count` updates at the edge. A credit returned at edge k enables a send at edge k+1 at the earliest.
- **Pointer wrap:** FIFO pointers wrap modulo `FIFO_DEPTH`. Full and empty are distinguished by count, not by pointer equality.
- **Output drive:** `d_out` is register-driven except in `conf_en`, where it is a combinational path from `in_data`.

## Test plan
- **Reset values:** after reset, check `credit_count = 2`, `fifo_count = 0`, `d_out = 0`. Push 0xA5A5A5A5 (valid) at edge 1 → `d_out = {0xA5A5A5A5, 1, 1}` for exactly one cycle after edge 2, and `credit_count = 1`.
- **Credit exhaustion:** push 4 tokens 1..4 with `c_in = 0` → tokens 1 and 2 are sent, then `credit_count = 0` and `fifo_count = 2`. One `c_in` pulse → token 3 is sent one edge later; token 4 is held.
- **Full FIFO:** fill 4 entries with 0 credits → `in_ready = 0` and a 5th push is dropped. A simultaneous pop with the 5th push still refuses that push.
- **Simultaneous send and return:** with `credit_count = 1`, a send and a `c_in` pulse in the same cycle → `credit_count` stays 1. A `c_in` at `credit_count = 2` with no send → the count stays 2 and `credit_err = 1` (sticky until reset).
- **Config mode:** `conf_en = 1` for 3 cycles with words 0x11, 0x22, 0x33 → `d_out = {word, 00}` in the same cycle for each. FIFO and credits are unchanged, and a queued token resumes sending the edge after `conf_en` drops. An invalid token 0x7 → `d_out[1:0] = 01`.
- **Reset mid-operation:** `rst` asserted with 3 tokens queued and 0 credits → the next cycle shows `fifo_count = 0`, `credit_count = 2`, `d_out = 0`, and no stale token is ever emitted.
